mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the pipeline's instruction-fetch port (read-only)
//  and the MEM-stage data port (read/write). Sits between the IF / MEM stages and the backing memory.
//  One transaction is outstanding at a time; data requests have priority, with a starvation guard for
//  fetch. The per-port stall outputs freeze the PC / IF-ID and the MEM-stage pipeline regs while a port waits.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive data grants allowed while fetch waits; 0 = strict data priority
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-high
//  if_req     in   1   fetch request; held high until if_rvalid
//  if_addr    in   32  fetch byte address
//  if_rvalid  out  1   fetch data valid (1-cycle pulse)
//  if_rdata   out  32  fetch data; 0 when if_rvalid=0
//  if_stall   out  1   if_req & ~if_rvalid
//  d_req      in   1   data request; held high until d_rvalid
//  d_we       in   1   1=store, 0=load
//  d_addr     in   32  data byte address
//  d_wdata    in   32  store data
//  d_rvalid   out  1   data txn done, for load or store (1-cycle pulse)
//  d_rdata    out  32  load data; 0 when d_rvalid=0 or on a store
//  d_stall    out  1   d_req & ~d_rvalid
//  m_req      out  1   memory request, registered
//  m_we       out  1   memory write enable, registered
//  m_addr     out  32  memory word-aligned address, registered, [1:0]=00
//  m_wdata    out  32  memory write data, registered
//  m_gnt      in   1   memory accepts request this cycle
//  m_rvalid   in   1   memory completion, read or write
//  m_rdata    in   32  memory read data
// BEHAVIOUR
//  Reset: state=IDLE, owner=NONE, streak=0; m_req=m_we=0, m_addr=m_wdata=0; all rvalid/rdata=0.
//  FSM IDLE -> REQ -> WAIT -> IDLE. Register `owner` is one of NONE, IF, D.
//   IDLE: if any request is high, choose the winner, latch its addr/we/wdata into m_* regs, and set
//         m_req=1 and the owner. Go to REQ on the next edge. Stay in IDLE if no request is high.
//   REQ: hold m_* stable until m_gnt. On m_gnt, drop m_req.
//         gnt & m_rvalid in the same cycle -> complete now, go to IDLE. gnt alone -> WAIT.
//   WAIT: on m_rvalid, complete and go to IDLE. m_rvalid seen in IDLE, or in REQ without gnt, is ignored.
//   Complete: pulse the owner's rvalid. Drive owner's rdata = m_rdata combinationally; force 0 for stores.
//         Then owner=NONE.
//  Arbitration (in IDLE only):
//   - d_req only -> D. if_req only -> IF.
//   - Both high and streak<STARVE_LIMIT -> D. Both high and streak>=STARVE_LIMIT -> IF.
//   - STARVE_LIMIT=0: both high -> always D.
//   - streak update: +1 on each D grant while if_req=1; cleared on any IF grant or whenever if_req=0.
//     Saturates at STARVE_LIMIT. Width $clog2(STARVE_LIMIT+1), min 1.
//  Latency: a grant decided in IDLE at edge N gives m_req=1 at N+1. Best case with gnt and rvalid in the
//   same cycle is a 2-cycle txn; that is also the minimum issue-to-issue spacing (no pipelined overlap).
//  Request drop mid-txn (req falls before rvalid): the txn still completes; the rvalid pulse is still
//   driven and the requester ignores it. A store already issued is never cancelled.
//  Address low bits: [1:0] are discarded (word access). No misalign error reported.
//  Reset mid-txn: FSM returns to IDLE at once; any pending m_rvalid afterwards is ignored.
//   The memory side must also be reset.
//  Simultaneous complete and new request: no same-cycle re-issue. Arbitration happens in the IDLE cycle after.
// STRUCTURE
//  Package mem_arb_pkg: arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT}; arb_owner_t {OWN_NONE, OWN_IF, OWN_D}.
//  Sub-module mem_arb_prio: combinational winner select plus the streak counter register.
//   The top level keeps the FSM, the m_* regs and response routing.
// TESTING
//  1 Reset: rst pulse mid-WAIT -> m_req=0, state IDLE, no rvalid; a late m_rvalid=1 produces no pulse.
//  2 Fetch only: if_addr=0x8, mem gnt+rvalid same cycle with rdata=0x00500093 -> if_rvalid 1 cycle,
//    if_rdata=0x00500093, m_addr=0x8.
//  3 Store then load: d_we=1 addr 0x10 wdata 0x2A, then d_we=0 addr 0x10 -> store d_rvalid with d_rdata=0;
//    load d_rdata=0x2A.
//  4 Contention, STARVE_LIMIT=4: d_req and if_req held high -> grant order D,D,D,D,IF,D...
//    if_stall high through the first 4 txns.
//  5 Slow memory: m_gnt delayed 3 cycles, m_rvalid 2 cycles after gnt -> m_* stable during REQ,
//    d_stall high until the d_rvalid cycle.
//  6 Misaligned/drop: d_addr=0x13 -> m_addr=0x10; if_req dropped in WAIT -> txn completes,
//    next grant goes to D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

  // Streak counter must hold 0..limit; a zero limit still gets one bit.
  function automatic int streak_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  // Memory is word addressed; the byte offset is simply dropped.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the backing-memory port of the arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold req until rvalid; memory side uses m_req/m_gnt.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_stall;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    output if_rvalid, if_rdata, if_stall, d_rvalid, d_rdata, d_stall,
           m_req, m_we, m_addr, m_wdata
  );

  // Pipeline-plus-memory view.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    input  if_rvalid, if_rdata, if_stall, d_rvalid, d_rdata, d_stall,
           m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Picks the winner between fetch and data requests, with a starvation guard for fetch.
// Latency: grant is combinational; the streak counter updates on the clock edge.
// Backpressure: grants only while arb_en (arbiter idle); losers simply keep waiting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

  localparam int SW = streak_width(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam bit STRICT = (STARVE_LIMIT == 0);

  logic [SW-1:0] streak_q;

  // Data wins unless fetch has already been passed over LIMIT times in a row.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (arb_en) begin
      grant_d  = d_req && (!if_req || STRICT || (streak_q < LIMIT));
      grant_if = if_req && !grant_d;
    end
  end

  // Count data grants that overtook a waiting fetch; reset whenever fetch is served or absent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (!if_req || grant_if) begin
      streak_q <= '0;
    end else if (grant_d && (streak_q < LIMIT)) begin
      streak_q <= streak_q + SW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM-stage data port.
// Latency: request issued to memory one cycle after arbitration; best case 2 cycles per txn.
// Backpressure: one txn outstanding; m_* held until m_gnt; waiting ports see their stall high.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        complete;
  logic        grant_if;
  logic        grant_d;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (state_q == ARB_IDLE),
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Next-state: issue on a grant, drop m_req on m_gnt, finish on m_rvalid (stray rvalid ignored).
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    complete  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          owner_d   = OWN_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = word_addr(bus.d_addr);
          m_wdata_d = bus.d_wdata;
          state_d   = ARB_REQ;
        end else if (grant_if) begin
          owner_d   = OWN_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = word_addr(bus.if_addr);
          m_wdata_d = '0;
          state_d   = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus.m_gnt) begin
          m_req_d = 1'b0;
          if (bus.m_rvalid) begin
            complete = 1'b1;
            owner_d  = OWN_NONE;
            state_d  = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (bus.m_rvalid) begin
          complete = 1'b1;
          owner_d  = OWN_NONE;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State, owner and the registered memory-side request; m_we/addr/wdata stay latched after gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_NONE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  // Response routing: completion pulses the owner; store completions return zero data.
  always_comb begin
    bus.if_rvalid = complete && (owner_q == OWN_IF);
    bus.d_rvalid  = complete && (owner_q == OWN_D);
    bus.if_rdata  = bus.if_rvalid ? bus.m_rdata : 32'h0;
    bus.d_rdata   = (bus.d_rvalid && !m_we_q) ? bus.m_rdata : 32'h0;
    bus.if_stall  = bus.if_req && !bus.if_rvalid;
    bus.d_stall   = bus.d_req && !bus.d_rvalid;
    bus.m_req     = m_req_q;
    bus.m_we      = m_we_q;
    bus.m_addr    = m_addr_q;
    bus.m_wdata   = m_wdata_q;
  end

endmodule
